// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multicycle RV64 control unit.
// Holds the FSM state encoding, instruction classes, opcode constants,
// ALU function codes, ALU B-source selects, splice (access width) codes
// and the funct3 -> splice mapping helper.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH0   = 4'd0,
    FETCH1   = 4'd1,
    DECODE   = 4'd2,
    R_EX     = 4'd3,
    I_EX     = 4'd4,
    LUI_EX   = 4'd5,
    WB_ALU   = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD0  = 4'd8,
    MEM_RD1  = 4'd9,
    WB_MEM   = 4'd10,
    MEM_WR   = 4'd11,
    BRANCH   = 4'd12,
    HALT     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_LUI     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SEQ   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] SPLICE_D = 2'b00;
  localparam logic [1:0] SPLICE_W = 2'b01;
  localparam logic [1:0] SPLICE_H = 2'b10;
  localparam logic [1:0] SPLICE_B = 2'b11;

  // Access-width map for loads/stores; returns {legal, splice}.
  function automatic logic [2:0] splice_map(input logic [2:0] funct3);
    logic [2:0] res;
    case (funct3)
      3'b011:  res = {1'b1, SPLICE_D};
      3'b010:  res = {1'b1, SPLICE_W};
      3'b001:  res = {1'b1, SPLICE_H};
      3'b000:  res = {1'b1, SPLICE_B};
      default: res = {1'b0, SPLICE_D};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational classification of the IR contents.
// Ports:
//   instruction_in - IR contents
//   instr_class    - instruction class (R, I, LOAD, STORE, BRANCH, LUI, ILLEGAL)
//   alu_op         - ALU function for the execute step of this instruction
//   splice         - load/store width select derived from funct3
//   legal          - funct fields form a supported instruction within its class
module instr_class_decode
  import control_pkg::*;
(
  input  logic [31:0]  instruction_in,
  output instr_class_t instr_class,
  output logic [3:0]   alu_op,
  output logic [1:0]   splice,
  output logic         legal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [2:0] map_s;
  logic       unused_fields_s;

  assign opcode_s        = instruction_in[6:0];
  assign funct3_s        = instruction_in[14:12];
  assign funct7_s        = instruction_in[31:25];
  assign map_s           = splice_map(funct3_s);
  // Register/immediate fields are the datapath's business, not the controller's.
  assign unused_fields_s = ^{instruction_in[24:15], instruction_in[11:7]};

  // Classify by opcode, then pick the ALU function and legality from funct fields.
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_ADD;
    splice      = SPLICE_D;
    legal       = 1'b0;
    case (opcode_s)
      OP_R: begin
        instr_class = CLS_R;
        legal       = 1'b1;
        case ({funct7_s, funct3_s})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_111: alu_op = ALU_AND;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_010: alu_op = ALU_SLT;
          default:         legal  = 1'b0;
        endcase
      end
      OP_I: begin
        instr_class = CLS_I;
        legal       = 1'b1;
        case (funct3_s)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b010:  alu_op = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OP_LOAD: begin
        instr_class     = CLS_LOAD;
        {legal, splice} = map_s;
      end
      OP_STORE: begin
        instr_class     = CLS_STORE;
        {legal, splice} = map_s;
      end
      OP_BRANCH: begin
        instr_class = CLS_BRANCH;
        legal       = 1'b1;
        case (funct3_s)
          3'b000:  alu_op = ALU_SUB;   // beq: taken when difference is zero
          3'b001:  alu_op = ALU_SEQ;   // bne: SEQ yields zero when operands differ
          default: legal  = 1'b0;
        endcase
      end
      OP_LUI: begin
        instr_class = CLS_LUI;
        alu_op      = ALU_PASSB;
        legal       = 1'b1;
      end
      OP_SYSTEM: instr_class = CLS_ILLEGAL;
      default:   instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle RV64 datapath.
// Ports:
//   clk, reset (synchronous, active low)
//   instruction_in - IR contents, stable from DECODE onward
//   PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut,
//   RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, LoadSplice,
//   StoreSplice, IMemRead, IRWrite - datapath control flags
//   halted    - set while parked in HALT
//   state_out - current state encoding for debug
// FETCH0 and MEM_RD0 repeat IMEM_LAT / DMEM_LAT times using a wait counter.
module multicycle_control
  import control_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        halted,
  output logic [3:0]  state_out
);

  localparam logic [1:0] IMEM_LAST = 2'(IMEM_LAT - 1);
  localparam logic [1:0] DMEM_LAST = 2'(DMEM_LAT - 1);

  state_t       state_r, next_state_s;
  logic [1:0]   wait_r;
  instr_class_t dec_class_s;
  logic [3:0]   dec_alu_op_s;
  logic [1:0]   dec_splice_s;
  logic         dec_legal_s;

  logic       pc_write_s, pc_write_cond_s, pc_source_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, load_splice_s, store_splice_s;
  logic [3:0] alu_op_s;
  logic       load_aout_s, reg_write_s, load_reg_a_s, load_reg_b_s;
  logic       mem_to_reg_s, dmem_op_s, load_mdr_s, imem_read_s, ir_write_s;

  instr_class_decode u_decode (
    .instruction_in (instruction_in),
    .instr_class    (dec_class_s),
    .alu_op         (dec_alu_op_s),
    .splice         (dec_splice_s),
    .legal          (dec_legal_s)
  );

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH0:   next_state_s = (wait_r == IMEM_LAST) ? FETCH1 : FETCH0;
      FETCH1:   next_state_s = DECODE;
      DECODE: begin
        case (dec_class_s)
          CLS_R:                next_state_s = R_EX;
          CLS_I:                next_state_s = I_EX;
          CLS_LOAD, CLS_STORE:  next_state_s = MEM_ADDR;
          CLS_BRANCH:           next_state_s = BRANCH;
          CLS_LUI:              next_state_s = LUI_EX;
          default:              next_state_s = HALT;
        endcase
      end
      R_EX, I_EX: next_state_s = dec_legal_s ? WB_ALU : HALT;
      LUI_EX:     next_state_s = WB_ALU;
      WB_ALU:     next_state_s = FETCH0;
      MEM_ADDR: begin
        if (!dec_legal_s) next_state_s = HALT;
        else if (dec_class_s == CLS_LOAD) next_state_s = MEM_RD0;
        else next_state_s = MEM_WR;
      end
      MEM_RD0:  next_state_s = (wait_r == DMEM_LAST) ? MEM_RD1 : MEM_RD0;
      MEM_RD1:  next_state_s = WB_MEM;
      WB_MEM:   next_state_s = FETCH0;
      MEM_WR:   next_state_s = FETCH0;
      BRANCH:   next_state_s = dec_legal_s ? FETCH0 : HALT;
      HALT:     next_state_s = HALT;
      default:  next_state_s = HALT;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= FETCH0;
      wait_r  <= 2'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == FETCH0 || state_r == MEM_RD0) && next_state_s == state_r) begin
        wait_r <= wait_r + 2'd1;
      end else begin
        wait_r <= 2'd0;
      end
    end
  end

  // Per-state control flags; anything not set in a state stays 0.
  always_comb begin
    pc_write_s = 1'b0; pc_write_cond_s = 1'b0; pc_source_s = 1'b0; alu_src_a_s = 1'b0;
    alu_src_b_s = SRCB_REG; alu_op_s = ALU_ADD; load_aout_s = 1'b0; reg_write_s = 1'b0;
    load_reg_a_s = 1'b0; load_reg_b_s = 1'b0; mem_to_reg_s = 1'b0; dmem_op_s = 1'b0;
    load_mdr_s = 1'b0; load_splice_s = SPLICE_D; store_splice_s = SPLICE_D;
    imem_read_s = 1'b0; ir_write_s = 1'b0;
    case (state_r)
      FETCH0: imem_read_s = 1'b1;
      FETCH1: begin
        imem_read_s = 1'b1; ir_write_s = 1'b1;
        alu_src_b_s = SRCB_FOUR; alu_op_s = ALU_ADD; pc_write_s = 1'b1;
      end
      DECODE: begin
        load_reg_a_s = 1'b1; load_reg_b_s = 1'b1;
        alu_src_b_s = SRCB_IMM2; alu_op_s = ALU_ADD; load_aout_s = 1'b1;
      end
      R_EX: begin
        alu_src_a_s = 1'b1; alu_src_b_s = SRCB_REG;
        alu_op_s = dec_alu_op_s; load_aout_s = dec_legal_s;
      end
      I_EX: begin
        alu_src_a_s = 1'b1; alu_src_b_s = SRCB_IMM;
        alu_op_s = dec_alu_op_s; load_aout_s = dec_legal_s;
      end
      LUI_EX: begin
        alu_src_b_s = SRCB_IMM; alu_op_s = ALU_PASSB; load_aout_s = 1'b1;
      end
      WB_ALU: reg_write_s = 1'b1;
      MEM_ADDR: begin
        alu_src_a_s = 1'b1; alu_src_b_s = SRCB_IMM;
        alu_op_s = ALU_ADD; load_aout_s = dec_legal_s;
      end
      MEM_RD0: imem_read_s = 1'b0;
      MEM_RD1: load_mdr_s = 1'b1;
      WB_MEM: begin
        reg_write_s = 1'b1; mem_to_reg_s = 1'b1; load_splice_s = dec_splice_s;
      end
      MEM_WR: begin
        dmem_op_s = 1'b1; store_splice_s = dec_splice_s;
      end
      BRANCH: begin
        alu_src_a_s = 1'b1; alu_src_b_s = SRCB_REG; pc_source_s = 1'b1;
        alu_op_s = dec_alu_op_s; pc_write_cond_s = dec_legal_s;
      end
      HALT:    imem_read_s = 1'b0;
      default: imem_read_s = 1'b0;
    endcase
  end

  // Reset holds every control flag low so nothing fires while reset is held.
  assign PCWrite     = reset & pc_write_s;
  assign PCWriteCond = reset & pc_write_cond_s;
  assign PCSource    = reset & pc_source_s;
  assign ALUSrcA     = reset & alu_src_a_s;
  assign ALUSrcB     = reset ? alu_src_b_s : 2'b00;
  assign ALUOp       = reset ? alu_op_s : 4'b0000;
  assign LoadAOut    = reset & load_aout_s;
  assign RegWrite    = reset & reg_write_s;
  assign LoadRegA    = reset & load_reg_a_s;
  assign LoadRegB    = reset & load_reg_b_s;
  assign MemToReg    = reset & mem_to_reg_s;
  assign DMemOp      = reset & dmem_op_s;
  assign LoadMDR     = reset & load_mdr_s;
  assign LoadSplice  = reset ? load_splice_s : 2'b00;
  assign StoreSplice = reset ? store_splice_s : 2'b00;
  assign IMemRead    = reset & imem_read_s;
  assign IRWrite     = reset & ir_write_s;
  assign halted      = reset & (state_r == HALT);
  assign state_out   = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of per-cycle expected
// states/flags plus hand-written sequences for halt, illegal funct, reset
// during writeback and a DMEM_LAT=2 load.
module tb_multicycle_control;
  import control_pkg::*;

  typedef struct packed {
    logic pcw; logic pcwc; logic pcsrc; logic srca; logic [1:0] srcb; logic [3:0] aluop;
    logic laout; logic regw; logic lra; logic lrb; logic m2r; logic dmem; logic lmdr;
    logic [1:0] lsp; logic [1:0] ssp; logic imr; logic irw; logic halted;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic [3:0]  st;
    ctl_t        ctl;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ir = 32'h0;

  logic pcw, pcwc, pcsrc, srca, laout, regw, lra, lrb, m2r, dmem, lmdr, imr, irw, hlt;
  logic [1:0] srcb, lsp, ssp;
  logic [3:0] aluop, state_out;
  logic d2_pcw, d2_pcwc, d2_pcsrc, d2_srca, d2_laout, d2_regw, d2_lra, d2_lrb, d2_m2r;
  logic d2_dmem, d2_lmdr, d2_imr, d2_irw, d2_hlt;
  logic [1:0] d2_srcb, d2_lsp, d2_ssp;
  logic [3:0] d2_aluop, d2_state;
  ctl_t act, act2;

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];
  state_t exp2[9] = '{FETCH0, FETCH1, DECODE, MEM_ADDR, MEM_RD0, MEM_RD0, MEM_RD1, WB_MEM, FETCH0};
  ctl_t c_zero, c_f0, c_f1, c_dec, c_radd, c_rsub, c_ior, c_lui, c_wbalu, c_maddr, c_mrd1;
  ctl_t c_wbmem_d, c_wbmem_b, c_mwr_d, c_mwr_w, c_beq, c_bne, c_halt;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction_in(ir),
    .PCWrite(pcw), .PCWriteCond(pcwc), .PCSource(pcsrc), .ALUSrcA(srca), .ALUSrcB(srcb),
    .ALUOp(aluop), .LoadAOut(laout), .RegWrite(regw), .LoadRegA(lra), .LoadRegB(lrb),
    .MemToReg(m2r), .DMemOp(dmem), .LoadMDR(lmdr), .LoadSplice(lsp), .StoreSplice(ssp),
    .IMemRead(imr), .IRWrite(irw), .halted(hlt), .state_out(state_out)
  );

  multicycle_control #(.IMEM_LAT(1), .DMEM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .instruction_in(ir),
    .PCWrite(d2_pcw), .PCWriteCond(d2_pcwc), .PCSource(d2_pcsrc), .ALUSrcA(d2_srca),
    .ALUSrcB(d2_srcb), .ALUOp(d2_aluop), .LoadAOut(d2_laout), .RegWrite(d2_regw),
    .LoadRegA(d2_lra), .LoadRegB(d2_lrb), .MemToReg(d2_m2r), .DMemOp(d2_dmem),
    .LoadMDR(d2_lmdr), .LoadSplice(d2_lsp), .StoreSplice(d2_ssp), .IMemRead(d2_imr),
    .IRWrite(d2_irw), .halted(d2_hlt), .state_out(d2_state)
  );

  assign act  = {pcw, pcwc, pcsrc, srca, srcb, aluop, laout, regw, lra, lrb, m2r, dmem, lmdr,
                 lsp, ssp, imr, irw, hlt};
  assign act2 = {d2_pcw, d2_pcwc, d2_pcsrc, d2_srca, d2_srcb, d2_aluop, d2_laout, d2_regw,
                 d2_lra, d2_lrb, d2_m2r, d2_dmem, d2_lmdr, d2_lsp, d2_ssp, d2_imr, d2_irw, d2_hlt};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] i, input state_t s, input ctl_t c,
                     input string n);
    vec_t v;
    v.rst = r; v.ir = i; v.st = s; v.ctl = c; v.name = n;
    vecs.push_back(v);
  endtask

  // Hold reset for one edge; returns #1 after the edge with reset released.
  task automatic do_reset(input logic [31:0] i);
    reset = 1'b0;
    ir = i;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic add_fetch(input logic [31:0] i, input string n);
    add(1'b1, i, FETCH0, c_f0, {n, " F0"});
    add(1'b0, i, FETCH1, c_f1, {n, " F1"});
    add(1'b0, i, DECODE, c_dec, {n, " DEC"});
  endtask

  initial begin
    c_zero = '0;
    c_f0 = '0; c_f0.imr = 1'b1;
    c_f1 = '0; c_f1.imr = 1'b1; c_f1.irw = 1'b1; c_f1.pcw = 1'b1; c_f1.srcb = 2'b01;
    c_dec = '0; c_dec.lra = 1'b1; c_dec.lrb = 1'b1; c_dec.srcb = 2'b11; c_dec.laout = 1'b1;
    c_radd = '0; c_radd.srca = 1'b1; c_radd.laout = 1'b1;
    c_rsub = c_radd; c_rsub.aluop = 4'b0001;
    c_ior = '0; c_ior.srca = 1'b1; c_ior.srcb = 2'b10; c_ior.aluop = 4'b0011; c_ior.laout = 1'b1;
    c_lui = '0; c_lui.srcb = 2'b10; c_lui.aluop = 4'b0111; c_lui.laout = 1'b1;
    c_wbalu = '0; c_wbalu.regw = 1'b1;
    c_maddr = '0; c_maddr.srca = 1'b1; c_maddr.srcb = 2'b10; c_maddr.laout = 1'b1;
    c_mrd1 = '0; c_mrd1.lmdr = 1'b1;
    c_wbmem_d = '0; c_wbmem_d.regw = 1'b1; c_wbmem_d.m2r = 1'b1;
    c_wbmem_b = c_wbmem_d; c_wbmem_b.lsp = 2'b11;
    c_mwr_d = '0; c_mwr_d.dmem = 1'b1;
    c_mwr_w = c_mwr_d; c_mwr_w.ssp = 2'b01;
    c_beq = '0; c_beq.srca = 1'b1; c_beq.pcwc = 1'b1; c_beq.pcsrc = 1'b1; c_beq.aluop = 4'b0001;
    c_bne = c_beq; c_bne.aluop = 4'b0110;
    c_halt = '0; c_halt.halted = 1'b1;

    // add x3,x1,x2
    add_fetch(32'h002081B3, "add");
    add(1'b0, 32'h002081B3, R_EX, c_radd, "add R_EX");
    add(1'b0, 32'h002081B3, WB_ALU, c_wbalu, "add WB");
    add(1'b0, 32'h002081B3, FETCH0, c_f0, "add next F0");
    // ld x5,8(x1)
    add_fetch(32'h0080B283, "ld");
    add(1'b0, 32'h0080B283, MEM_ADDR, c_maddr, "ld MEM_ADDR");
    add(1'b0, 32'h0080B283, MEM_RD0, c_zero, "ld MEM_RD0");
    add(1'b0, 32'h0080B283, MEM_RD1, c_mrd1, "ld MEM_RD1");
    add(1'b0, 32'h0080B283, WB_MEM, c_wbmem_d, "ld WB_MEM");
    add(1'b0, 32'h0080B283, FETCH0, c_f0, "ld next F0");
    // sd x5,16(x2)
    add_fetch(32'h00513823, "sd");
    add(1'b0, 32'h00513823, MEM_ADDR, c_maddr, "sd MEM_ADDR");
    add(1'b0, 32'h00513823, MEM_WR, c_mwr_d, "sd MEM_WR");
    add(1'b0, 32'h00513823, FETCH0, c_f0, "sd next F0");
    // beq x1,x2,8
    add_fetch(32'h00208463, "beq");
    add(1'b0, 32'h00208463, BRANCH, c_beq, "beq BRANCH");
    add(1'b0, 32'h00208463, FETCH0, c_f0, "beq next F0");
    // sub, ori, lui, sw, lb, bne
    add_fetch(32'h402081B3, "sub");
    add(1'b0, 32'h402081B3, R_EX, c_rsub, "sub R_EX");
    add(1'b0, 32'h402081B3, WB_ALU, c_wbalu, "sub WB");
    add_fetch(32'h00506093, "ori");
    add(1'b0, 32'h00506093, I_EX, c_ior, "ori I_EX");
    add(1'b0, 32'h00506093, WB_ALU, c_wbalu, "ori WB");
    add_fetch(32'h123450B7, "lui");
    add(1'b0, 32'h123450B7, LUI_EX, c_lui, "lui EX");
    add(1'b0, 32'h123450B7, WB_ALU, c_wbalu, "lui WB");
    add_fetch(32'h00512823, "sw");
    add(1'b0, 32'h00512823, MEM_ADDR, c_maddr, "sw MEM_ADDR");
    add(1'b0, 32'h00512823, MEM_WR, c_mwr_w, "sw MEM_WR");
    add_fetch(32'h00808283, "lb");
    add(1'b0, 32'h00808283, MEM_ADDR, c_maddr, "lb MEM_ADDR");
    add(1'b0, 32'h00808283, MEM_RD0, c_zero, "lb MEM_RD0");
    add(1'b0, 32'h00808283, MEM_RD1, c_mrd1, "lb MEM_RD1");
    add(1'b0, 32'h00808283, WB_MEM, c_wbmem_b, "lb WB_MEM");
    add_fetch(32'h00209463, "bne");
    add(1'b0, 32'h00209463, BRANCH, c_bne, "bne BRANCH");
    // ebreak (last: the halt sequence below continues from here)
    add_fetch(32'h00100073, "ebreak");
    add(1'b0, 32'h00100073, HALT, c_halt, "ebreak HALT");

    // Reset state: flags forced low while reset is held, state FETCH0 after an edge.
    @(negedge clk);
    check("reset flags", 32'(act), 32'(c_zero));
    @(posedge clk); #1;
    @(negedge clk);
    check("reset state", 32'(state_out), 32'(FETCH0));
    check("reset flags after edge", 32'(act), 32'(c_zero));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(vecs[i].ir);
      else ir = vecs[i].ir;
      @(negedge clk);
      check({vecs[i].name, " state"}, 32'(state_out), 32'(vecs[i].st));
      check({vecs[i].name, " flags"}, 32'(act), 32'(vecs[i].ctl));
      @(posedge clk); #1;
    end

    // HALT is absorbing with only halted set.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt hold", 32'({state_out, act}), 32'({HALT, c_halt}));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("halt during reset", 32'(act), 32'(c_zero));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("halt release state", 32'(state_out), 32'(FETCH0));
    check("halt release flags", 32'(act), 32'(c_f0));

    // Unsupported R-type funct7 (mul): no ALUOut load, then HALT.
    @(posedge clk); #1;
    do_reset(32'h022081B3);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mul R_EX state", 32'(state_out), 32'(R_EX));
    check("mul R_EX laout/regw", 32'({laout, regw}), 32'(2'b00));
    @(posedge clk); #1;
    @(negedge clk);
    check("mul then HALT", 32'({state_out, act}), 32'({HALT, c_halt}));

    // DMEM_LAT=2 load: two MEM_RD0 cycles, 8 cycles total, one RegWrite.
    @(posedge clk); #1;
    do_reset(32'h0080B283);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("lat2 ld cycle %0d state", c + 1), 32'(d2_state), 32'(exp2[c]));
      check($sformatf("lat2 ld cycle %0d regw", c + 1), 32'(act2.regw), 32'(c == 7));
      @(posedge clk); #1;
    end

    // Reset asserted during WB_MEM: flags drop that cycle, restart at FETCH0.
    do_reset(32'h0080B283);
    repeat (6) @(posedge clk);
    #1;
    check("ld WB_MEM reached", 32'(state_out), 32'(WB_MEM));
    reset = 1'b0;
    #1;
    check("reset in WB_MEM flags", 32'(act), 32'(c_zero));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset in WB_MEM next state", 32'(state_out), 32'(FETCH0));
    check("reset in WB_MEM next flags", 32'(act), 32'(c_f0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
